gnn_result_collector: RTL and testbench

//  Sits downstream of the 2-layer, 4-node GNN/DNN top.

---
 rtl/gnn_result_collector_pkg.sv | 21 ++
 rtl/gnn_result_collector_margin_sat.sv | 32 +++
 rtl/gnn_result_collector.sv | 159 +++++++++++++++
 tb/tb_gnn_result_collector.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gnn_result_collector_pkg.sv
// Shared types and defaults for the GNN result collector.
// The optional capture timeout is enabled with the RESULT_TIMEOUT_EN macro.
package gnn_result_collector_pkg;

  typedef enum logic [1:0] {
    COL_IDLE    = 2'd0,
    COL_COLLECT = 2'd1,
    COL_DRAIN   = 2'd2
  } collector_state_t;

  localparam int RES_W_DEF          = 21;
  localparam int NUM_NODES_DEF      = 4;
  localparam int MARGIN_W_DEF       = 16;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  // Width of an index/counter able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gnn_result_collector_margin_sat.sv
// margin_sat: signed out1 - out0 saturated to MARGIN_W bits, plus the class bit.
module gnn_result_collector_margin_sat #(
  parameter int RES_W    = 21,
  parameter int MARGIN_W = 16
) (
  input  logic [RES_W-1:0]    out0,
  input  logic [RES_W-1:0]    out1,
  output logic [MARGIN_W-1:0] margin,
  output logic                cls
);

  localparam logic signed [RES_W:0] SAT_MAX =
    $signed({{(RES_W+2-MARGIN_W){1'b0}}, {(MARGIN_W-1){1'b1}}});
  localparam logic signed [RES_W:0] SAT_MIN =
    $signed({{(RES_W+2-MARGIN_W){1'b1}}, {(MARGIN_W-1){1'b0}}});

  logic signed [RES_W:0] diff;

  always_comb begin
    // One guard bit makes the subtraction of two RES_W values exact.
    diff = $signed({out1[RES_W-1], out1}) - $signed({out0[RES_W-1], out0});
    if (diff > SAT_MAX) begin
      margin = SAT_MAX[MARGIN_W-1:0];
    end else if (diff < SAT_MIN) begin
      margin = SAT_MIN[MARGIN_W-1:0];
    end else begin
      margin = diff[MARGIN_W-1:0];
    end
    cls = ~diff[RES_W] & (|diff);
  end

endmodule

// File: rtl/gnn_result_collector.sv
// Captures per-node GNN outputs, then streams one classified record per node.
// Define RESULT_TIMEOUT_EN to force a drain of an incomplete frame after TIMEOUT_CYCLES.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// COL_IDLE    | no slot held, waiting for the first strobe of a frame
// COL_COLLECT | some slots held, capturing until the mask is complete
// COL_DRAIN   | frame frozen, records presented in node order on m_*
module gnn_result_collector
  import gnn_result_collector_pkg::*;
#(
  parameter int NUM_NODES      = NUM_NODES_DEF,
  parameter int RES_W          = RES_W_DEF,
  parameter int MARGIN_W       = MARGIN_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_NODES-1:0][1:0][RES_W-1:0]   res_val,
  input  logic [NUM_NODES-1:0][1:0]              res_strb,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [idx_width(NUM_NODES)-1:0]        m_node,
  output logic                                   m_class,
  output logic [MARGIN_W-1:0]                    m_margin,
  output logic                                   m_last,
  output logic                                   m_err,
  output logic                                   busy,
  output logic                                   drop_err
);

  localparam int IDX_W = idx_width(NUM_NODES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

  collector_state_t                 state_q, state_d;
  logic [NUM_NODES-1:0][1:0]        mask_q, mask_d;
  logic [NUM_NODES-1:0][1:0][RES_W-1:0] bank_q, bank_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic                             drop_q, drop_d;
  logic                             leave;
  logic                             cap_en;

`ifdef RESULT_TIMEOUT_EN
  localparam int TO_W = idx_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    bank_d  = bank_q;
    idx_d   = idx_q;
    drop_d  = drop_q;
    leave   = (state_q == COL_DRAIN) && m_ready && (idx_q == LAST_IDX);
    // Capture is open outside DRAIN and on the very edge that leaves it.
    cap_en  = (state_q != COL_DRAIN) || leave;

    if (state_q == COL_DRAIN) begin
      if (m_ready) begin
        if (idx_q == LAST_IDX) begin
          state_d = COL_IDLE;
          mask_d  = '0;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      if ((|res_strb) && !leave) begin
        drop_d = 1'b1;
      end
    end

    if (cap_en) begin
      for (int n = 0; n < NUM_NODES; n++) begin
        for (int s = 0; s < 2; s++) begin
          if (res_strb[n][s]) begin
            bank_d[n][s] = res_val[n][s];
          end
        end
      end
      mask_d = mask_d | res_strb;
      if (&mask_d) begin
        state_d = COL_DRAIN;
      end else if (|mask_d) begin
        state_d = COL_COLLECT;
      end
    end

`ifdef RESULT_TIMEOUT_EN
    cnt_d = cnt_q;
    if (state_q == COL_COLLECT) begin
      if (state_d == COL_COLLECT) begin
        if (cnt_q == '0) begin
          state_d = COL_DRAIN;
        end else begin
          cnt_d = cnt_q - TO_W'(1);
        end
      end
    end else if (state_d == COL_COLLECT) begin
      cnt_d = TO_LOAD;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COL_IDLE;
      mask_q  <= '0;
      bank_q  <= '0;
      idx_q   <= '0;
      drop_q  <= 1'b0;
`ifdef RESULT_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      bank_q  <= bank_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
`ifdef RESULT_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Record fields: slots never captured this frame read as zero.
  logic [RES_W-1:0]    sel_out0, sel_out1;
  logic [MARGIN_W-1:0] sat_margin;
  logic                sat_class;

  assign sel_out0 = mask_q[idx_q][0] ? bank_q[idx_q][0] : '0;
  assign sel_out1 = mask_q[idx_q][1] ? bank_q[idx_q][1] : '0;

  gnn_result_collector_margin_sat #(
    .RES_W    (RES_W),
    .MARGIN_W (MARGIN_W)
  ) u_margin_sat (
    .out0   (sel_out0),
    .out1   (sel_out1),
    .margin (sat_margin),
    .cls    (sat_class)
  );

  assign m_valid  = (state_q == COL_DRAIN);
  assign m_node   = m_valid ? idx_q : '0;
  assign m_class  = m_valid & sat_class;
  assign m_margin = m_valid ? sat_margin : '0;
  assign m_last   = m_valid & (idx_q == LAST_IDX);
`ifdef RESULT_TIMEOUT_EN
  assign m_err    = m_valid & ~(&mask_q[idx_q]);
`else
  assign m_err    = 1'b0;
`endif
  assign busy     = (state_q != COL_IDLE);
  assign drop_err = drop_q;

endmodule

// File: tb/tb_gnn_result_collector.sv
// Self-checking bench for gnn_result_collector: vector table, directed corners, random frames.
module tb_gnn_result_collector;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [3:0][1:0][20:0]   res_val;
  logic [3:0][1:0]         res_strb;
  logic                    m_valid, m_ready;
  logic [1:0]              m_node;
  logic                    m_class, m_last, m_err, busy, drop_err;
  logic [15:0]             m_margin;

  int n_checks = 0;
  int n_fail   = 0;

  int mo[4][2];
  bit mh[4][2];

  typedef struct {
    int o0;
    int o1;
    int margin;
    bit cls;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  gnn_result_collector dut (
    .clk      (clk),
    .rst      (rst),
    .res_val  (res_val),
    .res_strb (res_strb),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_node   (m_node),
    .m_class  (m_class),
    .m_margin (m_margin),
    .m_last   (m_last),
    .m_err    (m_err),
    .busy     (busy),
    .drop_err (drop_err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_model();
    for (int n = 0; n < 4; n++)
      for (int s = 0; s < 2; s++) mh[n][s] = 1'b0;
  endtask

  task automatic put(input int n, input int s, input int v);
    res_val[n][s]  = 21'(v);
    res_strb[n][s] = 1'b1;
    mo[n][s] = v;
    mh[n][s] = 1'b1;
  endtask

  function automatic int exp_diff(input int n);
    int a, b;
    a = mh[n][0] ? mo[n][0] : 0;
    b = mh[n][1] ? mo[n][1] : 0;
    return b - a;
  endfunction

  function automatic int exp_margin(input int n);
    int d;
    d = exp_diff(n);
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return d;
  endfunction

  task automatic chk_rec(input int n);
    chk("rec_valid", int'(m_valid), 1);
    chk("rec_node", int'(m_node), n);
    chk("rec_margin", int'($signed(m_margin)), exp_margin(n));
    chk("rec_class", int'(m_class), (exp_diff(n) > 0) ? 1 : 0);
    chk("rec_last", int'(m_last), (n == 3) ? 1 : 0);
    chk("rec_err", int'(m_err), (mh[n][0] && mh[n][1]) ? 0 : 1);
  endtask

  task automatic drain_frame(input bit rnd, input int nrec);
    for (int n = 0; n < nrec; n++) begin
      bit acc;
      int g;
      acc = 1'b0;
      g = 0;
      while (!acc && g < 40) begin
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        chk_rec(n);
        acc = m_ready;
        tick();
        g++;
      end
      if (!acc) chk("drain_budget", 0, 1);
    end
    m_ready = 1'b0;
  endtask

  task automatic expect_idle(input string nm);
    chk({nm, "_valid"}, int'(m_valid), 0);
    chk({nm, "_busy"}, int'(busy), 0);
  endtask

  function automatic int rv();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 2097151)) - 1048576;
    return int'($urandom_range(0, 80000)) - 40000;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{-1000000, 1000000, 32767, 1'b1};
    tbl[1] = '{1000000, -1000000, -32768, 1'b0};
    tbl[2] = '{123, 123, 0, 1'b0};
    tbl[3] = '{0, 5, 5, 1'b1};
    tbl[4] = '{100, 32867, 32767, 1'b1};
    tbl[5] = '{100, 32868, 32767, 1'b1};
    tbl[6] = '{0, -32768, -32768, 1'b0};
    tbl[7] = '{0, -32769, -32768, 1'b0};

    rst = 1'b1;
    res_val = '0;
    res_strb = '0;
    m_ready = 1'b0;
    clr_model();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(m_valid), 0);
    tick();
    rst = 1'b0;
    chk("rst_drop", int'(drop_err), 0);
    chk("rst_margin", int'(m_margin), 0);
    chk("rst_node", int'(m_node), 0);
    chk("rst_flags", int'({m_class, m_last, m_err}), 0);

    // T1: whole frame in one cycle
    for (int n = 0; n < 4; n++) begin
      put(n, 0, 10 * n);
      put(n, 1, 10 * n + 5);
    end
    chk("t1_pre_valid", int'(m_valid), 0);
    tick();
    res_strb = '0;
    chk("t1_margin0", int'($signed(m_margin)), 5);
    chk("t1_class0", int'(m_class), 1);
    drain_frame(1'b0, 4);
    expect_idle("t1_end");

    // T2: table of saturation / tie vectors, four per frame
    for (int f = 0; f < 2; f++) begin
      clr_model();
      for (int n = 0; n < 4; n++) begin
        put(n, 0, tbl[f*4+n].o0);
        put(n, 1, tbl[f*4+n].o1);
      end
      tick();
      res_strb = '0;
      m_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
        chk("t2_valid", int'(m_valid), 1);
        chk("t2_margin", int'($signed(m_margin)), tbl[f*4+n].margin);
        chk("t2_class", int'(m_class), int'(tbl[f*4+n].cls));
        tick();
      end
      m_ready = 1'b0;
      expect_idle("t2_end");
    end

    // T3: backpressure holds node0; a strobe in DRAIN is dropped
    clr_model();
    for (int n = 0; n < 4; n++) begin
      put(n, 0, 3 * n + 1);
      put(n, 1, -7 * n);
    end
    tick();
    res_strb = '0;
    chk("t3_drop_pre", int'(drop_err), 0);
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_node", int'(m_node), 0);
      chk("t3_hold_margin", int'($signed(m_margin)), exp_margin(0));
      if (c == 2) begin
        res_val[1][0] = 21'(5555);
        res_strb[1][0] = 1'b1;
      end
      tick();
      res_strb = '0;
    end
    chk("t3_drop_set", int'(drop_err), 1);
    drain_frame(1'b0, 4);
    expect_idle("t3_end");

    // T4: spread strobes with a repeated slot
    begin
      int sn[9] = '{0, 0, 1, 2, 1, 2, 2, 3, 3};
      int ss[9] = '{0, 1, 0, 1, 1, 1, 0, 0, 1};
      int sv[9] = '{11, 22, 33, 7, 44, 9, 2, 55, 66};
      clr_model();
      for (int i = 0; i < 9; i++) begin
        put(sn[i], ss[i], sv[i]);
        tick();
        res_strb = '0;
        chk("t4_valid", int'(m_valid), (i == 8) ? 1 : 0);
        chk("t4_busy", int'(busy), 1);
      end
      chk("t4_node2_model", exp_margin(2), 7);
      drain_frame(1'b0, 4);
      expect_idle("t4_end");
    end

    // T5: reset mid-frame discards captured slots
    clr_model();
    put(0, 0, 1); tick(); res_strb = '0;
    put(0, 1, 2); tick(); res_strb = '0;
    put(1, 0, 3); tick(); res_strb = '0;
    put(1, 1, 4); tick(); res_strb = '0;
    put(3, 1, 5); tick(); res_strb = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_valid", int'(m_valid), 0);
    chk("t5_drop", int'(drop_err), 0);
    clr_model();
    for (int n = 0; n < 4; n++) begin
      put(n, 0, 100 + n);
      if (n != 3) put(n, 1, -200 * n);
    end
    tick();
    res_strb = '0;
    chk("t5_partial_valid", int'(m_valid), 0);
    put(3, 1, 999);
    tick();
    res_strb = '0;
    drain_frame(1'b0, 4);
    expect_idle("t5_end");

    // T7: strobe on the edge leaving DRAIN opens the next frame
    clr_model();
    for (int n = 0; n < 4; n++) begin
      put(n, 0, n);
      put(n, 1, 2 * n);
    end
    tick();
    res_strb = '0;
    drain_frame(1'b0, 3);
    m_ready = 1'b1;
    chk_rec(3);
    clr_model();
    put(0, 0, 777);
    tick();
    res_strb = '0;
    m_ready = 1'b0;
    chk("t7_busy", int'(busy), 1);
    chk("t7_valid", int'(m_valid), 0);
    put(0, 1, 700);
    for (int n = 1; n < 4; n++) begin
      put(n, 0, -n);
      put(n, 1, n);
    end
    tick();
    res_strb = '0;
    drain_frame(1'b0, 4);
    expect_idle("t7_end");

`ifdef RESULT_TIMEOUT_EN
    // T6: incomplete frame forced out by the timeout
    begin
      int cyc;
      clr_model();
      put(0, 0, 10); put(0, 1, 40);
      put(1, 0, 50); put(1, 1, 20);
      tick();
      res_strb = '0;
      cyc = 0;
      while (!m_valid && cyc < 200) begin
        tick();
        cyc++;
      end
      chk("t6_timeout_cycles", cyc, 64);
      drain_frame(1'b0, 4);
      expect_idle("t6_end");
    end
`endif

    // Random frames against the model
    for (int f = 0; f < 20; f++) begin
      int order[8];
      int ptr;
      clr_model();
      for (int i = 0; i < 8; i++) order[i] = i;
      for (int i = 7; i > 0; i--) begin
        int j, t;
        j = int'($urandom_range(0, i));
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      ptr = 0;
      while (ptr < 8) begin
        int k, base;
        base = ptr;
        k = int'($urandom_range(1, (8 - ptr) < 3 ? (8 - ptr) : 3));
        for (int i = 0; i < k; i++) begin
          put(order[ptr] / 2, order[ptr] % 2, rv());
          ptr++;
        end
        if (base > 0 && $urandom_range(0, 3) == 0) begin
          int r;
          r = order[$urandom_range(0, base - 1)];
          put(r / 2, r % 2, rv());
        end
        chk("rnd_collect_valid", int'(m_valid), 0);
        tick();
        res_strb = '0;
        if (ptr < 8) begin
          int gap;
          gap = int'($urandom_range(0, 2));
          for (int g = 0; g < gap; g++) begin
            chk("rnd_gap_valid", int'(m_valid), 0);
            tick();
          end
        end
      end
      drain_frame(1'b1, 4);
      expect_idle("rnd_end");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
